// File: rtl/stream_normalizer.sv
// stream_normalizer: repacks ragged byte beats into dense beats without merging packets
module stream_normalizer #(
  parameter int DATA_BYTES = 8,
  localparam int CW = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [CW-1:0]           in_cnt,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [CW-1:0]           out_cnt,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int W = 8*DATA_BYTES;
  localparam logic [CW:0] DB = (CW+1)'(DATA_BYTES);
  logic [W-1:0] buf_q, bmask;
  logic [CW-1:0] buf_cnt;
  logic flush, emit, full, over, acc;
  logic [CW:0] n_in, total;
  logic [2*W-1:0] merged;
  always_comb begin
    n_in = (in_cnt == '0) ? DB : {1'b0, in_cnt};
    total = {1'b0, buf_cnt} + n_in;
    bmask = ~({W{1'b1}} << {buf_cnt, 3'b000});
    merged = {{W{1'b0}}, buf_q & bmask} | ({{W{1'b0}}, in_data} << {buf_cnt, 3'b000});
    full = total >= DB;
    over = total > DB;
    emit = full || in_last;
    in_ready = rst_n && !flush && (!emit || out_ready);
    out_valid = rst_n && (flush || (in_valid && emit));
    out_data = flush ? buf_q : merged[W-1:0];
    out_cnt = flush ? buf_cnt : full ? '0 : total[CW-1:0];
    out_last = flush || (in_last && !over);
    acc = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_cnt <= '0;
      flush <= 1'b0;
    end else if (flush) begin
      if (out_ready) begin
        buf_cnt <= '0;
        flush <= 1'b0;
      end
    end else if (acc) begin
      buf_q <= emit ? merged[2*W-1:W] : merged[W-1:0];
      buf_cnt <= (emit && !over) ? '0 : total[CW-1:0];
      flush <= emit && over && in_last;
    end
  end
endmodule

// File: tb/tb_stream_normalizer.sv
// tb_stream_normalizer: vector table, corner sequences and randomized packets vs a byte-queue model
module tb_stream_normalizer;
  typedef struct {
    logic [63:0] d;
    logic [2:0]  c;
    logic        l, v, r, ev, er;
    logic [63:0] ed;
    logic [2:0]  ec;
    logic        el;
  } vec_t;
  typedef struct {
    logic [63:0] d;
    logic [2:0]  c;
    logic        l;
  } beat_t;
  localparam logic [63:0] D = 64'h0123456789abcdef;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] in_data = '0, out_data;
  logic [2:0] in_cnt = '0, out_cnt;
  logic in_last = 1'b0, in_valid = 1'b0, in_ready, out_last, out_valid, out_ready = 1'b0;
  int total = 0, bad = 0;
  vec_t tbl[14];
  logic [63:0] bd[$];
  logic [2:0] bc[$];
  logic bl[$];
  beat_t eq[$];
  logic [7:0] pkt[$];
  stream_normalizer #(.DATA_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_cnt(out_cnt),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] msk(input logic [2:0] c);
    return (c == 3'd0) ? 64'hffffffffffffffff : ~(64'hffffffffffffffff << {c, 3'b000});
  endfunction
  function automatic vec_t mk(input logic [63:0] d, input logic [2:0] c, input logic l, input logic v,
                              input logic r, input logic ev, input logic er, input logic [63:0] ed,
                              input logic [2:0] ec, input logic el);
    vec_t t;
    t.d = d; t.c = c; t.l = l; t.v = v; t.r = r; t.ev = ev; t.er = er; t.ed = ed; t.ec = ec; t.el = el;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask
  task automatic drive(input logic [63:0] d, input logic [2:0] c, input logic l, input logic v, input logic r);
    in_data = d; in_cnt = c; in_last = l; in_valid = v; out_ready = r;
  endtask
  task automatic step_chk(input string nm, input logic ev, input logic er, input logic [63:0] ed,
                          input logic [2:0] ec, input logic el);
    @(negedge clk);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({nm, ".in_ready"}, 64'(in_ready), 64'(er));
    if (ev) begin
      chk({nm, ".data"}, out_data & msk(ec), ed & msk(ec));
      chk({nm, ".cnt"}, 64'(out_cnt), 64'(ec));
      chk({nm, ".last"}, 64'(out_last), 64'(el));
    end
    @(posedge clk); #1;
  endtask
  initial begin
    automatic int bi = 0, cyc = 0;
    automatic logic acc;
    automatic beat_t e;
    tbl[0]  = mk(D, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    tbl[1]  = mk(D, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h89abcdef89abcdef, 3'd0, 1'b1);
    tbl[2]  = mk(D, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h89abcdef, 3'd4, 1'b1);
    tbl[3]  = mk(D, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, D, 3'd0, 1'b1);
    tbl[4]  = mk(D, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    tbl[5]  = mk(D, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hef23456789abcdef, 3'd0, 1'b0);
    tbl[6]  = mk(D, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0123456789abcd, 3'd7, 1'b1);
    tbl[7]  = mk(D, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    tbl[8]  = mk(D, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'habcdefabcdef, 3'd6, 1'b1);
    tbl[9]  = mk(D, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    tbl[10] = mk(D, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    tbl[11] = mk(D, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h456789abcdefcdef, 3'd0, 1'b0);
    tbl[12] = mk(D, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h456789abcdefcdef, 3'd0, 1'b0);
    tbl[13] = mk(D, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    @(posedge clk); #1;
    drive(D, 3'd0, 1'b1, 1'b1, 1'b1);
    step_chk("reset", 1'b0, 1'b0, 64'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].d, tbl[i].c, tbl[i].l, tbl[i].v, tbl[i].r);
      step_chk($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ed, tbl[i].ec, tbl[i].el);
    end
    drive(D, 3'd7, 1'b0, 1'b1, 1'b1);
    step_chk("a_first", 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    drive(D, 3'd7, 1'b1, 1'b1, 1'b1);
    step_chk("a_full", 1'b1, 1'b1, 64'hef23456789abcdef, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(D, 3'd0, 1'b0, 1'b0, 1'b0);
      step_chk("a_hold", 1'b1, 1'b0, 64'h23456789abcd, 3'd6, 1'b1);
    end
    drive(D, 3'd0, 1'b0, 1'b0, 1'b1);
    step_chk("a_drain", 1'b1, 1'b0, 64'h23456789abcd, 3'd6, 1'b1);
    step_chk("a_after", 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(64'hef, 3'd1, 1'b0, 1'b1, 1'b0);
      step_chk("b_acc", 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(64'hef, 3'd1, 1'b0, 1'b1, 1'b0);
      step_chk("b_stall", 1'b1, 1'b0, 64'hefefefefefefefef, 3'd0, 1'b0);
    end
    drive(64'hef, 3'd1, 1'b1, 1'b1, 1'b1);
    step_chk("b_last", 1'b1, 1'b1, 64'hefefefefefefefef, 3'd0, 1'b1);
    drive(64'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    step_chk("b_idle", 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    drive(D, 3'd3, 1'b0, 1'b1, 1'b1);
    step_chk("c_part", 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    rst_n = 1'b0;
    drive(D, 3'd4, 1'b1, 1'b1, 1'b1);
    step_chk("c_rst", 1'b0, 1'b0, 64'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step_chk("c_fresh", 1'b1, 1'b1, 64'h89abcdef, 3'd4, 1'b1);
    drive(D, 3'd7, 1'b0, 1'b1, 1'b1);
    step_chk("c_p7", 1'b0, 1'b1, 64'h0, 3'd0, 1'b0);
    drive(D, 3'd0, 1'b1, 1'b1, 1'b1);
    step_chk("c_p8", 1'b1, 1'b1, 64'hef23456789abcdef, 3'd0, 1'b0);
    rst_n = 1'b0;
    drive(D, 3'd0, 1'b0, 1'b0, 1'b0);
    step_chk("c_rst2", 1'b0, 1'b0, 64'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step_chk("c_noflush", 1'b0, 1'b0, 64'h0, 3'd0, 1'b0);
    drive(D, 3'd4, 1'b1, 1'b1, 1'b1);
    step_chk("c_fresh2", 1'b1, 1'b1, 64'h89abcdef, 3'd4, 1'b1);
    for (int p = 0; p < 40; p++) begin
      automatic int nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        automatic logic [63:0] d = {$urandom, $urandom};
        automatic int n = $urandom_range(1, 8);
        bd.push_back(d);
        bc.push_back(3'(n % 8));
        bl.push_back(b == nb - 1);
        for (int k = 0; k < n; k++) pkt.push_back(d[8*k +: 8]);
      end
      while (pkt.size() > 0) begin
        automatic int n = (pkt.size() > 8) ? 8 : pkt.size();
        automatic beat_t x;
        x.d = '0;
        for (int k = 0; k < n; k++) x.d[8*k +: 8] = pkt.pop_front();
        x.c = 3'(n % 8);
        x.l = (pkt.size() == 0);
        eq.push_back(x);
      end
    end
    drive(64'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    while ((bi < bd.size() || eq.size() > 0) && cyc < 20000) begin
      if (!in_valid && bi < bd.size() && $urandom_range(0, 3) != 0) begin
        in_data = bd[bi]; in_cnt = bc[bi]; in_last = bl[bi]; in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (eq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_extra got=%h expected=no beat", out_data);
        end else begin
          e = eq.pop_front();
          chk("rnd.data", out_data & msk(e.c), e.d & msk(e.c));
          chk("rnd.cnt", 64'(out_cnt), 64'(e.c));
          chk("rnd.last", 64'(out_last), 64'(e.l));
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        bi++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    chk("rnd_pending_out", 64'(eq.size()), 64'd0);
    chk("rnd_beats_in", 64'(bi), 64'(bd.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_normalizer.md
Name: stream_normalizer

Overview:
- Byte-stream repacker. It accepts beats carrying 1..DATA_BYTES valid bytes and emits beats that are always completely full, except the final beat of a packet, which may be partial.
- Sits between a producer that emits ragged beats and a consumer that expects dense beats.
- Uses a valid/ready handshake on both sides.
- Low-latency: a beat that completes an output word is forwarded combinationally in the same cycle it is accepted.

Parameters:
- DATA_BYTES, default 8, bytes per beat. Must be a power of two and at least 2.
- CW (derived, not overridable), $clog2(DATA_BYTES), width of the count fields.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  8*DATA_BYTES  input bytes. Byte i is bits [8i+7:8i]. Valid bytes are the low in_cnt bytes.
- in_cnt  input  CW  valid byte count of the input beat; 0 encodes DATA_BYTES (full).
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- out_data  output  8*DATA_BYTES  packed output bytes, low-aligned.
- out_cnt  output  CW  valid byte count of the output beat; 0 encodes DATA_BYTES.
- out_last  output  1  marks the final beat of a packet.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- State registers:
  - buf: DATA_BYTES bytes.
  - buf_cnt: 0..DATA_BYTES-1 bytes held.
  - flush: 1 = a terminal residue is pending.
- Reset (rst_n low at the clock edge): buf_cnt=0, flush=0. While rst_n is low, in_ready=0 and out_valid=0.
- Decoding: n_in = (in_cnt==0) ? DATA_BYTES : in_cnt; total = buf_cnt + n_in, range 1..2*DATA_BYTES-1.
- Merged word: buf in the low buf_cnt bytes, then the in_data bytes starting at byte position buf_cnt. The oldest bytes occupy the lowest positions.
- Normal mode (flush=0):
  - emit = (total >= DATA_BYTES) || in_last.
  - in_ready = !emit || out_ready. This depends combinationally on buf_cnt, in_cnt, in_last and out_ready, not on in_valid.
  - out_valid = in_valid && emit. This is a combinational path from the input side.
  - out_data = low DATA_BYTES bytes of the merged word.
  - out_cnt = (total >= DATA_BYTES) ? 0 : total.
  - out_last = in_last && (total <= DATA_BYTES).
- On an accepted input (in_valid && in_ready):
  - !emit: buf gets the merged bytes, buf_cnt = total.
  - emit and total <= DATA_BYTES: buf_cnt = 0.
  - emit and total > DATA_BYTES: buf gets merged bytes [DATA_BYTES .. total-1], shifted down to byte 0; buf_cnt = total - DATA_BYTES. If in_last=1, flush=1.
- Flush mode (flush=1):
  - in_ready=0.
  - out_valid=1, out_data=buf, out_cnt=buf_cnt, out_last=1.
  - On out_ready: buf_cnt=0, flush=0.
  - One cycle later in_ready follows the normal-mode rule.
- Byte positions at or above out_cnt (when out_cnt != 0) are don't-care. Checkers must mask them.
- An input beat is never split across two acceptances. It is either fully consumed or stalled (in_ready=0).
- Backpressure: with out_ready=0, input beats that do not complete a word are still accepted and buffered. A beat that would complete a word, or any in_last beat, stalls.
- Packet boundaries: bytes from different packets are never merged into one output beat. The last output beat of each packet carries out_last=1.
- Reset mid-packet discards the buffered bytes and any pending flush.

Test Plan:
- DATA_BYTES=8, out_ready=1. Input 64'h0123456789abcdef cnt 4 !last gives no output. Then 64'h0123456789abcdef cnt 4 last gives one output in the same cycle: 64'h89abcdef89abcdef, cnt 0, last=1.
- Input cnt 7 !last, then cnt 7 last (same data), out_ready dropped after the second beat:
  - Output 1: 64'hef23456789abcdef, cnt 0, last=0.
  - Afterwards in_ready=0 and out_valid=1 with out_last=1, held until out_ready=1.
  - Output 2: low 6 bytes 23456789abcd, cnt 6, last=1.
- Single terminal beats:
  - cnt 4 last gives low bytes 89abcdef, cnt 4, last=1.
  - cnt 0 last gives 64'h0123456789abcdef, cnt 0, last=1.
- Input cnt 7 !last, then cnt 0 last:
  - 64'hef23456789abcdef, cnt 0, last=0.
  - Next cycle: low 7 bytes 0123456789abcd, cnt 7, last=1.
- out_ready=0, eight 1-byte beats (byte ef):
  - Beats 1–7 are accepted.
  - Beat 8 (!last) sees in_ready=0.
  - After out_ready=1, the 8th beat sent with last gives 64'hefefefefefefefef, cnt 0, last=1.
- Input cnt 3 !last, then cnt 3 last gives low bytes abcdefabcdef, cnt 6, last=1. Reset asserted mid-packet then clears buf_cnt, so the next packet starts at byte 0.
